// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and the control FSM that drives it.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

    localparam logic [5:0] LW = 6'b001000;
    localparam logic [5:0] SW = 6'b010000;

    // Index width that stays legal for depths of 0 or 1.
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the multicycle control FSM (master) and the memory (slave).
interface mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              memRead;
    logic              memWrite;
    logic [31:0]       addr;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              memReady;
    logic              busy;
    logic              addrErr;

    modport master (
        output memRead, memWrite, addr, writeData,
        input  readData, memReady, busy, addrErr
    );

    modport slave (
        input  memRead, memWrite, addr, writeData,
        output readData, memReady, busy, addrErr
    );
endinterface

// File: rtl/mem_word_array.sv
// Word array with a synchronous write port and a registered, enable-held read port.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Contents are deliberately left out of reset.
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write at a time, inserts WAIT_CYCLES wait states,
// then pulses memReady; bad requests are rejected with a one-cycle addrErr.
//
//   state | meaning
//   IDLE  | ready to accept; memReady/addrErr of the previous access are visible here
//   WAIT  | wait-state countdown, request already captured
//   RESP  | write committed on entry; read data latched on exit
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);

    localparam int AW     = idx_width(DEPTH_WORDS);
    localparam int CNT_W  = idx_width(WAIT_CYCLES + 1);
    localparam int WIDX_W = 32 - BYTE_SHIFT;
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [5:0]        op_q;
    logic              mem_ready_q;
    logic              addr_err_q;

    logic              req;
    logic              req_bad;
    logic              accept;
    logic [AW-1:0]     req_word;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    assign req      = bus.memRead | bus.memWrite;
    assign req_word = bus.addr[AW+BYTE_SHIFT-1:BYTE_SHIFT];
    assign req_bad  = (bus.addr[BYTE_SHIFT-1:0] != '0)
                    | (bus.addr[31:BYTE_SHIFT] >= DEPTH_LIM)
                    | (bus.memRead & bus.memWrite);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = addr_q;
        wr_data      = wdata_q;
        rd_en        = 1'b0;
        case (state)
            IDLE: begin
                if (req && !req_bad) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the accept edge is also the edge entering RESP.
                        state_nxt = RESP;
                        wr_en     = bus.memWrite;
                        wr_addr   = req_word;
                        wr_data   = bus.writeData;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == CNT_ONE) begin
                    state_nxt    = RESP;
                    wait_cnt_nxt = '0;
                    wr_en        = (op_q == SW);
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_ONE;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                rd_en     = (op_q == LW);
            end
            default: state_nxt = IDLE;
        endcase
        // A write whose commit edge coincides with reset is dropped.
        if (reset) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            mem_ready_q <= 1'b0;
            addr_err_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= LW;
        end else begin
            wait_cnt    <= wait_cnt_nxt;
            mem_ready_q <= (state == RESP);
            addr_err_q  <= (state == IDLE) & req & req_bad;
            if (accept) begin
                addr_q  <= req_word;
                wdata_q <= bus.writeData;
                op_q    <= bus.memWrite ? SW : LW;
            end
        end
    end

    mem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (addr_q),
        .rd_data (rd_data)
    );

    assign bus.readData = rd_data;
    assign bus.memReady = mem_ready_q;
    assign bus.busy     = (state != IDLE);
    assign bus.addrErr  = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a schedule-level model checks the default build every cycle,
// directed sequences pin latencies and data; a second build covers zero wait states.
module tb_mem_responder;

    localparam int W0    = 2;
    localparam int DEPTH = 256;

    logic clk;
    logic reset;

    mem_responder_if #(.DATA_W(32)) bus0 ();
    mem_responder_if #(.DATA_W(32)) bus1 ();

    mem_responder #(.DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_responder #(.DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-access schedule in cycle numbers (cycle k follows posedge k).
    int          ek = 0;
    bit          model_on = 0;
    int          busy_lo, busy_hi, ready_at, err_at, free_at, commit_at;
    bit          pend_wr, pend_rd;
    int          pend_idx;
    logic [31:0] pend_data;
    logic [31:0] exp_rdata;
    bit          rdata_known;
    logic [31:0] mmem [int];

    always @(posedge clk) begin
        logic [31:0] a;
        ek++;
        if (reset) begin
            model_on    = 1;
            busy_lo     = -1;
            busy_hi     = -2;
            ready_at    = -1;
            err_at      = -1;
            commit_at   = -1;
            free_at     = ek + 1;
            pend_wr     = 0;
            pend_rd     = 0;
            exp_rdata   = 32'h0;
            rdata_known = 1;
        end else if (model_on) begin
            if (ek >= free_at && (bus0.memRead || bus0.memWrite)) begin
                a = bus0.addr;
                if ((a % 32'd4) != 0 || (a / 32'd4) >= DEPTH || (bus0.memRead && bus0.memWrite)) begin
                    err_at  = ek;
                    free_at = ek + 1;
                end else begin
                    busy_lo  = ek;
                    busy_hi  = ek + W0;
                    ready_at = ek + W0 + 1;
                    free_at  = ek + W0 + 2;
                    pend_idx = int'(a / 32'd4);
                    if (bus0.memWrite) begin
                        pend_wr   = 1;
                        commit_at = ek + W0;
                        pend_data = bus0.writeData;
                    end else begin
                        pend_rd = 1;
                    end
                end
            end
            if (pend_wr && commit_at == ek) begin
                mmem[pend_idx] = pend_data;
                pend_wr = 0;
            end
            if (pend_rd && ready_at == ek) begin
                pend_rd = 0;
                if (mmem.exists(pend_idx)) begin
                    exp_rdata   = mmem[pend_idx];
                    rdata_known = 1;
                end else begin
                    rdata_known = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy", {31'b0, bus0.busy}, {31'b0, (ek >= busy_lo && ek <= busy_hi)});
            check("memReady", {31'b0, bus0.memReady}, {31'b0, (ek == ready_at)});
            check("addrErr", {31'b0, bus0.addrErr}, {31'b0, (ek == err_at)});
            if (rdata_known) check("readData", bus0.readData, exp_rdata);
        end
    end

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.memRead = rd; bus0.memWrite = wr; bus0.addr = a; bus0.writeData = d;
        end else begin
            bus1.memRead = rd; bus1.memWrite = wr; bus1.addr = a; bus1.writeData = d;
        end
    endtask

    // Issue one request, drop it (and scramble addr/data) after the accept edge, observe 10 cycles.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int nready, output int nerr, output int nbusy);
        logic r, e, b;
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        lat = -1; nready = 0; nerr = 0; nbusy = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) drive(sel, 1'b0, 1'b0, 32'hFFFF_FFF0, ~d);
            r = (sel == 0) ? bus0.memReady : bus1.memReady;
            e = (sel == 0) ? bus0.addrErr  : bus1.addrErr;
            b = (sel == 0) ? bus0.busy     : bus1.busy;
            if (r) begin
                nready++;
                if (lat < 0) lat = i;
            end
            if (e) nerr++;
            if (b) nbusy++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nr, ne, nb, first, second, cnt;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset readData0", bus0.readData, 32'h0);
        check("reset busy0", {31'b0, bus0.busy}, 32'h0);
        check("reset memReady1", {31'b0, bus1.memReady}, 32'h0);
        check("reset readData1", bus1.readData, 32'h0);

        // Write then read back.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, nr, ne, nb);
        check("t1 wr latency", 32'(lat), 32'd4);
        check("t1 wr busy cycles", 32'(nb), 32'd3);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, nr, ne, nb);
        check("t1 rd latency", 32'(lat), 32'd4);
        check("t1 rd readData", bus0.readData, 32'hDEADBEEF);
        check("t1 rd ready count", 32'(nr), 32'd1);

        access(0, 1'b0, 1'b1, 32'h0,  32'h11223344, lat, nr, ne, nb);
        access(0, 1'b0, 1'b1, 32'h20, 32'hAAAA5555, lat, nr, ne, nb);
        check("write keeps readData", bus0.readData, 32'hDEADBEEF);

        // Misaligned read.
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, lat, nr, ne, nb);
        check("t3 addrErr count", 32'(ne), 32'd1);
        check("t3 no memReady", 32'(nr), 32'd0);
        check("t3 readData held", bus0.readData, 32'hDEADBEEF);

        // Out-of-range write, then the neighbouring word must be untouched.
        access(0, 1'b0, 1'b1, 32'h400, 32'h55555555, lat, nr, ne, nb);
        check("t4 addrErr count", 32'(ne), 32'd1);
        check("t4 no memReady", 32'(nr), 32'd0);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, nr, ne, nb);
        check("t4 read 0x0", bus0.readData, 32'h11223344);

        // Read and write together.
        access(0, 1'b1, 1'b1, 32'h10, 32'h0, lat, nr, ne, nb);
        check("both addrErr", 32'(ne), 32'd1);
        check("both no memReady", 32'(nr), 32'd0);

        // Request held through memReady and one more cycle.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        first = -1; second = -1; cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (first >= 0 && i == first + 1) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (bus0.memReady) begin
                cnt++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        check("t5 first latency", 32'(first), 32'd4);
        check("t5 ready spacing", 32'(second - first), 32'd4);
        check("t5 ready count", 32'(cnt), 32'd2);

        // Reset during the wait states of a write.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        check("t6 busy before reset", {31'b0, bus0.busy}, 32'h1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("t6 busy after reset", {31'b0, bus0.busy}, 32'h0);
        reset = 1'b0;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, nr, ne, nb);
        check("t6 read 0x20", bus0.readData, 32'hAAAA5555);
        check("t6 write dropped", {31'b0, (bus0.readData != 32'h12345678)}, 32'h1);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, nr, ne, nb);
        check("t6 committed kept", bus0.readData, 32'hDEADBEEF);

        // Zero-wait-state build.
        access(1, 1'b0, 1'b1, 32'h0, 32'hCAFE0001, lat, nr, ne, nb);
        check("t2 wr latency", 32'(lat), 32'd2);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, lat, nr, ne, nb);
        check("t2 rd latency", 32'(lat), 32'd2);
        check("t2 busy cycles", 32'(nb), 32'd1);
        check("t2 readData", bus1.readData, 32'hCAFE0001);
        check("t2 ready count", 32'(nr), 32'd1);
        access(1, 1'b1, 1'b0, 32'h3FC, 32'h0, lat, nr, ne, nb);
        check("t2 last word latency", 32'(lat), 32'd2);
        check("t2 last word no err", 32'(ne), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
